coriolis_div_share_arb: RTL and testbench
=========================================

Name: coriolis_div_share_arb

Overview:
- Time-multiplexes one pipelined FP divider (FloPoCo format, 34-bit operands, fixed latency) between NREQ requester streams in the coriolis kernel.
- Round-robin grants one operand pair per cycle and drives the divider's X/Y/stall inputs.
- Carries a requester-ID tag pipeline aligned with divider latency and steers each result back to its owner with valid/ready backpressure.
- Sits between subkernel streams and a single divider instance; the divider is external and connected through div_* ports.

Parameters:
- STREAMW, 34: operand/result width (2-bit FloPoCo exception field + 32-bit float).
- NREQ, 2: number of requesters (2..4).
- IDW, 1: tag width, equal to clog2(NREQ) with minimum 1.
- LAT, 13: divider latency in non-stalled cycles.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ivalid  in  NREQ  per-requester operand valid
- iready  out  NREQ  per-requester accept, one-hot or zero
- in_x  in  NREQ*STREAMW  packed dividends; requester i occupies slice [i*STREAMW +: STREAMW]
- in_y  in  NREQ*STREAMW  packed divisors, same packing as in_x
- ovalid  out  NREQ  per-requester result valid
- oready  in  NREQ  per-requester result ready
- out1  out  STREAMW  result data, broadcast to all requesters
- div_x  out  STREAMW  to divider X
- div_y  out  STREAMW  to divider Y
- div_stall  out  1  to divider stall
- div_r  in  STREAMW  from divider R

Behaviour:
- Reset (rst low, asynchronous):
  - all tag-pipe valids clear; rr pointer = NREQ-1, so requester 0 has first priority.
  - ovalid=0, iready=0, div_stall=0 while in reset.
- Tag pipe:
  - LAT stages of {v, id}; head = stage LAT-1.
  - On each edge with stall=0: shift; stage0 <= {grant_any, gid}.
  - On each edge with stall=1: hold.
- stall = head.v & ~oready[head.id].
  - div_stall = stall.
  - A head bubble (head.v=0) never stalls.
- Arbitration (combinational):
  - When stall=0, grant the first requester with ivalid=1, searching from rr+1 modulo NREQ.
  - iready[gid]=1 for the granted requester; all other iready=0.
  - When stall=1, all iready=0.
  - Requesters must not make ivalid depend on iready.
- Pointer update: rr <= gid on an edge with a grant; otherwise unchanged.
- Datapath:
  - div_x/div_y = granted requester's in_x/in_y slices; all-zero when there is no grant.
  - The divider samples them on the same edge the tag enters stage0.
- Output:
  - ovalid[i] = head.v & (head.id==i); out1 = div_r.
  - A transfer occurs when ovalid[i] & oready[i].
  - Latency: operand accepted at edge k → result presented after LAT non-stalled edges; 1 result/cycle sustained.
- Boundary conditions:
  - Any requester holding oready low blocks the whole pipe (head-of-line); other requesters are not granted until it drains.
  - Simultaneous all-valid requests are served strictly in rotation.
  - A single requester gets back-to-back grants.
  - Reset asserted mid-operation discards all in-flight results; no ovalid is asserted after reset releases until new operands complete LAT.

Optional Feature:
- Macro: CORIOLIS_DIV_ARB_PERF_EN.
- Defined:
  - adds input perf_clr (1), output perf_grant_cnt (NREQ*32), output perf_stall_cnt (32).
  - grant counters increment per grant; the stall counter increments per stall cycle.
  - counters are 32-bit and saturate at 0xFFFFFFFF.
  - synchronous clear on perf_clr; asynchronous clear on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester 0 streams 20 pairs (x=1000.0, y=10.0) with oready=all 1 → iready0 high every cycle; first ovalid[0] after 13 edges; 20 consecutive results of 100.0; ovalid[1] never asserted.
- Both requesters continuously valid → grants alternate 0,1,0,1 starting with 0; results return in the same alternating order with matching IDs.
- Result at head for requester 1 with oready[1]=0 held 5 cycles → div_stall=1, iready=0, ovalid[1] held with out1 stable for 5 cycles; resumes with no data lost or duplicated.
- Sparse ivalid (one pair every 3 cycles) → bubbles pass through, no stall, each result exactly 13 cycles after acceptance.
- rst pulsed low mid-stream with 6 ops in flight → ovalid drops immediately; after release no stale ovalid; the next grant goes to requester 0.
- With CORIOLIS_DIV_ARB_PERF_EN defined: 7 grants to requester 0, 4 to requester 1, 3 stall cycles → perf_grant_cnt={4,7}, perf_stall_cnt=3; perf_clr → all counters 0.

Source files
------------

// File: rtl/coriolis_div_share_arb_if.sv
// Requester-side bundle: operand stream in, result stream out.
// master = requesters, slave = arbiter.
interface coriolis_div_share_arb_if #(
    parameter int NREQ    = 2,
    parameter int STREAMW = 34
);
    logic [NREQ-1:0]         ivalid;
    logic [NREQ-1:0]         iready;
    logic [NREQ*STREAMW-1:0] in_x;
    logic [NREQ*STREAMW-1:0] in_y;
    logic [NREQ-1:0]         ovalid;
    logic [NREQ-1:0]         oready;
    logic [STREAMW-1:0]      out1;

    modport master (
        output ivalid, in_x, in_y, oready,
        input  iready, ovalid, out1
    );

    modport slave (
        input  ivalid, in_x, in_y, oready,
        output iready, ovalid, out1
    );
endinterface

// File: rtl/coriolis_div_share_arb.sv
// coriolis_div_share_arb: round-robin sharing of one pipelined FP divider
// between NREQ streams; an ID tag pipe steers each result to its owner.
// Ports: clk, rst (async active-low); bus (slave side of
// coriolis_div_share_arb_if: ivalid/iready/in_x/in_y/ovalid/oready/out1);
// div_x/div_y/div_stall drive the divider, div_r is its result.
// Optional macro CORIOLIS_DIV_ARB_PERF_EN adds perf_clr, perf_grant_cnt,
// perf_stall_cnt (saturating 32-bit grant and stall counters).
module coriolis_div_share_arb #(
    parameter int STREAMW = 34,
    parameter int NREQ    = 2,
    parameter int IDW     = (NREQ > 2) ? $clog2(NREQ) : 1,
    parameter int LAT     = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    coriolis_div_share_arb_if.slave  bus,
    output logic [STREAMW-1:0]       div_x,
    output logic [STREAMW-1:0]       div_y,
    output logic                     div_stall,
    input  logic [STREAMW-1:0]       div_r
`ifdef CORIOLIS_DIV_ARB_PERF_EN
    ,
    input  logic                     perf_clr,
    output logic [NREQ*32-1:0]       perf_grant_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    logic [LAT-1:0] r_v;
    logic [IDW-1:0] r_id [LAT];
    logic [IDW-1:0] r_rr;

    logic           w_stall;
    logic           w_gany;
    logic [IDW-1:0] w_gid;
    logic [IDW-1:0] w_hid;

    assign w_hid     = r_id[LAT-1];
    // An empty head slot never blocks the pipe.
    assign w_stall   = r_v[LAT-1] & ~bus.oready[w_hid];
    assign div_stall = w_stall;
    assign bus.out1  = div_r;

    // Pick the requester with the smallest rotational distance past r_rr.
    always_comb begin : arb
        int d;
        int best;
        d     = 0;
        best  = NREQ;
        w_gid = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + 2 * NREQ - int'(r_rr) - 1) % NREQ;
            if (bus.ivalid[i] && d < best) begin
                best  = d;
                w_gid = IDW'(i);
            end
        end
        w_gany = (best < NREQ) && !w_stall && rst;
    end

    always_comb begin
        bus.iready = '0;
        bus.ovalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.iready[i] = w_gany && (w_gid == IDW'(i));
            bus.ovalid[i] = r_v[LAT-1] && (w_hid == IDW'(i));
        end
    end

    always_comb begin
        div_x = '0;
        div_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.iready[i]) begin
                div_x = bus.in_x[i*STREAMW +: STREAMW];
                div_y = bus.in_y[i*STREAMW +: STREAMW];
            end
        end
    end

    // Tag pipe advances in lockstep with the divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v  <= '0;
            r_rr <= IDW'(NREQ - 1);
            for (int i = 0; i < LAT; i++) begin
                r_id[i] <= '0;
            end
        end else if (!w_stall) begin
            r_v     <= {r_v[LAT-2:0], w_gany};
            r_id[0] <= w_gid;
            for (int i = 1; i < LAT; i++) begin
                r_id[i] <= r_id[i-1];
            end
            if (w_gany) begin
                r_rr <= w_gid;
            end
        end
    end

`ifdef CORIOLIS_DIV_ARB_PERF_EN
    logic [31:0] r_gcnt [NREQ];
    logic [31:0] r_scnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scnt <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_gcnt[i] <= '0;
            end
        end else if (perf_clr) begin
            r_scnt <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_gcnt[i] <= '0;
            end
        end else begin
            if (w_stall && (r_scnt != '1)) begin
                r_scnt <= r_scnt + 32'd1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.iready[i] && (r_gcnt[i] != '1)) begin
                    r_gcnt[i] <= r_gcnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            perf_grant_cnt[i*32 +: 32] = r_gcnt[i];
        end
    end

    assign perf_stall_cnt = r_scnt;
`endif

endmodule

// File: tb/tb_coriolis_div_share_arb.sv
// Bench for coriolis_div_share_arb: divider stub plus a queue-based
// reference model of grants, latency, stalls and result steering.
module tb_coriolis_div_share_arb;
    localparam int W   = 34;
    localparam int N   = 2;
    localparam int IDW = 1;
    localparam int LAT = 13;

    typedef logic [IDW-1:0] id_t;
    typedef struct {
        id_t          id;
        logic [W-1:0] d;
        int           age;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    coriolis_div_share_arb_if #(.NREQ(N), .STREAMW(W)) bus ();

    logic [W-1:0] div_x;
    logic [W-1:0] div_y;
    logic [W-1:0] div_r;
    logic         div_stall;
    logic [W-1:0] xs [N];
    logic [W-1:0] ys [N];

`ifdef CORIOLIS_DIV_ARB_PERF_EN
    logic          perf_clr;
    logic [N*32-1:0] perf_grant_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    coriolis_div_share_arb #(
        .STREAMW(W), .NREQ(N), .IDW(IDW), .LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_stall (div_stall),
        .div_r     (div_r)
`ifdef CORIOLIS_DIV_ARB_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always_comb begin
        bus.in_x = '0;
        bus.in_y = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_x[i*W +: W] = xs[i];
            bus.in_y[i*W +: W] = ys[i];
        end
    end

    // Stand-in for the external divider: any fixed function of X and Y,
    // LAT deep, frozen while stalled.
    function automatic logic [W-1:0] fdiv(logic [W-1:0] x, logic [W-1:0] y);
        return (x ^ {y[W-2:0], y[W-1]}) + W'(7);
    endfunction

    logic [W-1:0] dpipe [LAT];
    always @(posedge clk) begin
        if (!div_stall) begin
            dpipe[0] <= fdiv(div_x, div_y);
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end
    end
    assign div_r = dpipe[LAT-1];

    int   checks = 0;
    int   fails  = 0;
    ent_t q [$];
    id_t  m_rr;
    int   gcnt [N];
    int   scnt;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_rr = id_t'(N - 1);
        scnt = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endtask

    // Predict this cycle's outputs, compare, then apply the coming edge.
    task automatic model_step();
        logic         hv;
        id_t          hid;
        logic         estall;
        logic         gv;
        id_t          g;
        id_t          j;
        logic [N-1:0] eov;
        logic [N-1:0] eir;
        logic [W-1:0] ex;
        if (!rst) begin
            chk("rst_iready", 64'(bus.iready), 64'(0));
            chk("rst_ovalid", 64'(bus.ovalid), 64'(0));
            chk("rst_stall", 64'(div_stall), 64'(0));
            return;
        end
        hv     = (q.size() > 0) && (q[0].age == LAT);
        hid    = hv ? q[0].id : id_t'(0);
        estall = hv && !bus.oready[hid];
        eov    = hv ? (N'(1) << hid) : '0;
        gv     = 1'b0;
        g      = '0;
        if (!estall) begin
            for (int k = 1; k <= N; k++) begin
                j = id_t'((int'(m_rr) + k) % N);
                if (!gv && bus.ivalid[j]) begin
                    gv = 1'b1;
                    g  = j;
                end
            end
        end
        eir = gv ? (N'(1) << g) : '0;
        ex  = gv ? xs[g] : '0;
        chk("iready", 64'(bus.iready), 64'(eir));
        chk("ovalid", 64'(bus.ovalid), 64'(eov));
        chk("stall", 64'(div_stall), 64'(estall));
        chk("div_x", 64'(div_x), 64'(ex));
        if (hv) chk("out1", 64'(bus.out1), 64'(q[0].d));
        if (estall) begin
            scnt++;
        end else begin
            if (hv) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (gv) begin
                q.push_back('{g, fdiv(xs[g], ys[g]), 1});
                m_rr = g;
                gcnt[g]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            xs[i] = W'({$urandom(), $urandom()});
            ys[i] = W'({$urandom(), $urandom()});
        end
    endtask

    task automatic drain();
        bus.ivalid = '0;
        bus.oready = '1;
        repeat (LAT + 4) tick();
        chk("drained", 64'(q.size()), 64'(0));
    endtask

    initial begin
        bus.ivalid = '0;
        bus.oready = '1;
`ifdef CORIOLIS_DIV_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            xs[i] = '0;
            ys[i] = '0;
        end
        model_clear();
        repeat (2) tick();
        #2 rst = 1'b1;

        // Single requester streams 1000.0 / 10.0.
        xs[0] = {2'b01, 32'h447A0000};
        ys[0] = {2'b01, 32'h41200000};
        bus.ivalid = 2'b01;
        repeat (20) tick();
        drain();

        // Both requesters continuously valid: strict alternation.
        bus.ivalid = 2'b11;
        repeat (20) begin
            rand_data();
            tick();
        end
        drain();

        // Requester 1 holds oready low while its result sits at head.
        bus.ivalid = 2'b11;
        repeat (4) begin
            rand_data();
            tick();
        end
        bus.ivalid = 2'b00;
        bus.oready = 2'b01;
        repeat (LAT + 6) tick();
        drain();

        // Sparse traffic: one pair every third cycle.
        repeat (8) begin
            rand_data();
            bus.ivalid = N'($urandom_range(1, 3));
            tick();
            bus.ivalid = '0;
            repeat (2) tick();
        end
        drain();

        // Random traffic and backpressure.
        repeat (300) begin
            rand_data();
            bus.ivalid = N'($urandom());
            for (int i = 0; i < N; i++)
                bus.oready[i] = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset pulsed mid-stream with results at the head.
        bus.ivalid = 2'b11;
        repeat (16) begin
            rand_data();
            tick();
        end
        #2 rst = 1'b0;
        #1;
        chk("rst_async_ovalid", 64'(bus.ovalid), 64'(0));
        chk("rst_async_iready", 64'(bus.iready), 64'(0));
        model_clear();
        repeat (2) tick();
        #2 rst = 1'b1;
        repeat (LAT + 4) begin
            rand_data();
            tick();
        end
        drain();

`ifdef CORIOLIS_DIV_ARB_PERF_EN
        for (int i = 0; i < N; i++)
            chk("perf_grant", 64'(perf_grant_cnt[i*32 +: 32]), 64'(gcnt[i]));
        chk("perf_stall", 64'(perf_stall_cnt), 64'(scnt));
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        chk("perf_clr_grant", 64'(perf_grant_cnt), 64'(0));
        chk("perf_clr_stall", 64'(perf_stall_cnt), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
